pic_host_sequencer: RTL
=======================

# pic_host_sequencer

CPU-side bus master for the 8259A PIC's read/write port. It turns single-cycle command requests into properly timed `cs_n`/`wr_n`/`rd_n`/`a0`/`d` bus cycles, and autonomously issues the ICW1–ICW4 initialization sequence. It also performs OCW writes and IRR/ISR/IMR reads. It sits between a testbench or soft CPU and the PIC, driving the interface that the PIC's read/write logic decodes.

## Interface
- `SETUP_CYC`, default 1: cycles with `cs_n`/`a0`/`d` valid before the strobe falls (≥1).
- `STROBE_CYC`, default 2: cycles `wr_n`/`rd_n` is held low (≥1).
- `HOLD_CYC`, default 1: cycles with `cs_n`/`a0`/`d` held after the strobe rises (≥1).
- `clk  in  1`: single clock; all logic is on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `cmd_valid  in  1`, `cmd_ready  out  1`: command handshake.
- `cmd_op  in  2`: 00 INIT, 01 WRITE, 10 READ, 11 reserved (rejected).
- `cmd_a0  in  1`, `cmd_data  in  8`: A0 level and write byte for WRITE; `cmd_a0` also applies to READ.
- `cfg_icw1`, `cfg_icw2`, `cfg_icw3`, `cfg_icw4`  `in  8` each: initialization words, sampled at INIT acceptance.
- `rsp_valid  out  1`, `rsp_data  out  8`: read result, valid for one cycle.
- `cmd_err  out  1`: one-cycle pulse when a command is rejected.
- `init_done  out  1`: the last INIT sequence completed.
- `cs_n`, `wr_n`, `rd_n  out  1`: PIC bus strobes (active low).
- `a0  out  1`, `d_out  out  8`, `d_oe  out  1`, `d_in  in  8`: PIC address and data bus.

## Operation
- Reset values: `cs_n`=`wr_n`=`rd_n`=1, `a0`=0, `d_out`=0, `d_oe`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `cmd_err`=0, `init_done`=0.
- Command acceptance: a command is accepted when `cmd_valid & cmd_ready`. `cmd_ready` is 1 only in IDLE. All command and config inputs are registered at acceptance.
- **INIT**
  - Clears `init_done` at acceptance.
  - Builds the word list: ICW1 (A0=0, driven as `cfg_icw1 | 0x10`, so D4 is forced), then ICW2 (A0=1).
  - ICW3 (A0=1) is sent only if `cfg_icw1[1]`=0 (cascade mode).
  - ICW4 (A0=1) is sent only if `cfg_icw1[0]`=1 (IC4).
  - Issues the words back to back. Sets `init_done` on return to IDLE.
- **WRITE**: one write cycle with `cmd_a0`/`cmd_data`. The byte is sent unmodified; OCW1/2/3 selection is the caller's job.
- **READ**: one read cycle at `cmd_a0`. IRR/ISR selection relies on a previously written OCW3. `d_oe` stays 0.
- Rejection: WRITE or READ while `init_done`=0, or `cmd_op`=11, is accepted and dropped. `cmd_err` pulses the cycle after acceptance, with no bus activity.
- FSM: IDLE → SETUP → STROBE → HOLD → GAP → (next ICW: SETUP | IDLE). A per-phase down-counter is loaded with the phase length on entry.

## Timing
- The acceptance edge is cycle 0.
- Each bus cycle occupies `SETUP_CYC+STROBE_CYC+HOLD_CYC+1` cycles, 5 at defaults:
  - SETUP: `cs_n`=0, strobes high, `a0`/`d_out` valid, `d_oe`=1 for writes.
  - STROBE: `wr_n` or `rd_n`=0.
  - HOLD: strobe high, `cs_n`/`a0`/`d` unchanged.
  - GAP: `cs_n`=1, `d_oe`=0.
- All bus outputs are registered and glitch-free. Exactly one falling edge of `wr_n`/`rd_n` occurs per bus cycle.
- READ: `d_in` is captured on the edge that ends STROBE (the edge on which `rd_n` rises). `rsp_valid` and `cmd_ready` rise together in the first IDLE cycle.
- INIT latency at defaults: cycle 5N+1 is IDLE with `init_done`=1, where N is the number of ICWs (2–4). For 4 ICWs this is cycle 21.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously), the ICW index clears, and any pending response is lost.
- A `cmd_valid` held outside IDLE is ignored until `cmd_ready`=1.

## Structure
- Package `pic_host_pkg` holds:
  - the `cmd_op` encodings (`OP_INIT`, `OP_WRITE`, `OP_READ`);
  - the state enum;
  - ICW1 bit indices (`ICW1_IC4`=0, `ICW1_SNGL`=1, `ICW1_INIT`=4);
  - the ICW index type.
- Sub-module `pic_bus_cycle` owns the phase timing. It takes `start`, `is_read`, `a0`, `data` and produces the bus pins, `done`, and `rd_data`. The top level keeps the command FSM and the ICW list.

## Test plan
- Reset: after `rst_n` is released, `cs_n`/`wr_n`/`rd_n`=1, `d_oe`=0, `cmd_ready`=1, `init_done`=0.
- INIT full sequence: `cfg_icw1`=0x11, `cfg_icw2`=0x20, `cfg_icw3`=0x04, `cfg_icw4`=0x01 → writes (A0,D) = (0,0x11), (1,0x20), (1,0x04), (1,0x01), each with `wr_n` low for 2 cycles; `init_done`=1 at cycle 21.
- INIT reduced sequence: `cfg_icw1`=0x02 → exactly two writes, (0,0x12) then (1,`cfg_icw2`); `init_done`=1 at cycle 11.
- READ after init: READ with A0=1 and `d_in`=0xA5 → `rd_n` low for 2 cycles, `d_oe`=0 throughout, `rsp_valid`=1 with `rsp_data`=0xA5 for one cycle at cycle 6.
- Rejection: WRITE before init → `cmd_err` pulse at cycle 1, `cs_n` stays 1. `cmd_op`=11 after init → same response.
- Reset mid-INIT: `rst_n` asserted during the ICW2 STROBE → `wr_n`/`cs_n` go to 1 without waiting for a clock, `init_done`=0; a new INIT restarts at ICW1 (0,0x11).

Source files
------------

// File: rtl/pic_host_pkg.sv
// Shared types and constants for the 8259A host-side bus sequencer.
package pic_host_pkg;
  localparam logic [1:0] OP_INIT  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_INIT = 4;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_GAP} phase_t;
  typedef enum logic [1:0] {C_IDLE, C_LAUNCH, C_BUSY, C_ERR} cmd_st_t;

  typedef logic [1:0] icw_idx_t;
  typedef struct packed {
    logic     vld;
    icw_idx_t idx;
  } icw_nxt_t;

  // ICW2 always follows ICW1; ICW3 only in cascade mode, ICW4 only when IC4 is set.
  function automatic icw_nxt_t next_icw(icw_idx_t cur, logic [7:0] icw1);
    icw_nxt_t n;
    n.vld = 1'b0;
    n.idx = cur;
    case (cur)
      2'd0: begin n.vld = 1'b1; n.idx = 2'd1; end
      2'd1: begin
        if (!icw1[ICW1_SNGL])    begin n.vld = 1'b1; n.idx = 2'd2; end
        else if (icw1[ICW1_IC4]) begin n.vld = 1'b1; n.idx = 2'd3; end
      end
      2'd2: if (icw1[ICW1_IC4]) begin n.vld = 1'b1; n.idx = 2'd3; end
      default: ;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/pic_host_sequencer_if.sv
// Command, response and PIC bus signals of the host sequencer.
interface pic_host_sequencer_if;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_a0;
  logic [7:0] cmd_data;
  logic [7:0] cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       cmd_err, init_done;
  logic       cs_n, wr_n, rd_n, a0;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;

  modport master (
    output cmd_valid, cmd_op, cmd_a0, cmd_data,
           cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4, d_in,
    input  cmd_ready, rsp_valid, rsp_data, cmd_err, init_done,
           cs_n, wr_n, rd_n, a0, d_out, d_oe
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a0, cmd_data,
           cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4, d_in,
    output cmd_ready, rsp_valid, rsp_data, cmd_err, init_done,
           cs_n, wr_n, rd_n, a0, d_out, d_oe
  );
endinterface

// File: rtl/pic_bus_cycle.sv
// One timed PIC bus cycle: SETUP -> STROBE -> HOLD -> GAP, all pins registered.
module pic_bus_cycle import pic_host_pkg::*; #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       is_read,
  input  logic       a0,
  input  logic [7:0] data,
  input  logic [7:0] d_in,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       pin_a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       done,
  output logic [7:0] rd_data
);
  localparam int CW = 8;

  phase_t        st;
  logic [CW-1:0] cnt;
  logic          rd_q;

  // GAP lasts exactly one cycle, so it doubles as the completion flag.
  assign done = (st == ST_GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      cnt     <= '0;
      rd_q    <= 1'b0;
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      pin_a0  <= 1'b0;
      d_out   <= '0;
      d_oe    <= 1'b0;
      rd_data <= '0;
    end else begin
      case (st)
        ST_IDLE, ST_GAP: begin
          if (start) begin
            st     <= ST_SETUP;
            cnt    <= CW'(SETUP_CYC - 1);
            rd_q   <= is_read;
            cs_n   <= 1'b0;
            pin_a0 <= a0;
            d_out  <= data;
            d_oe   <= !is_read;
          end else begin
            st <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            st   <= ST_STROBE;
            cnt  <= CW'(STROBE_CYC - 1);
            wr_n <= rd_q;
            rd_n <= !rd_q;
          end
        end
        ST_STROBE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            st   <= ST_HOLD;
            cnt  <= CW'(HOLD_CYC - 1);
            wr_n <= 1'b1;
            rd_n <= 1'b1;
            if (rd_q) rd_data <= d_in;
          end
        end
        ST_HOLD: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            st   <= ST_GAP;
            cs_n <= 1'b1;
            d_oe <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/pic_host_sequencer.sv
// 8259A host bus master: command FSM and ICW list on top of pic_bus_cycle.
module pic_host_sequencer import pic_host_pkg::*; #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  pic_host_sequencer_if.slave bus
);
  cmd_st_t         st;
  logic            is_init, cmd_rd, cmd_a0_q;
  logic [7:0]      cmd_data_q;
  logic [3:0][7:0] icw_q;
  icw_idx_t        idx;
  logic            cmd_ready_q, rsp_valid_q, cmd_err_q, init_done_q;
  logic [7:0]      rsp_data_q;

  logic            bc_done;
  logic [7:0]      bc_rd_data;
  icw_nxt_t        nxt;
  logic            launch, more, start, w_a0;
  icw_idx_t        w_idx;
  logic [7:0]      w_data;

  assign nxt    = next_icw(idx, icw_q[0]);
  assign launch = (st == C_LAUNCH);
  assign more   = is_init & nxt.vld;
  // Next word is presented during GAP so the following SETUP starts with no idle cycle.
  assign start  = launch | ((st == C_BUSY) & bc_done & more);
  assign w_idx  = launch ? idx : nxt.idx;

  always_comb begin
    w_a0   = cmd_a0_q;
    w_data = cmd_data_q;
    if (is_init) begin
      w_a0   = (w_idx != 2'd0);
      w_data = icw_q[w_idx];
      if (w_idx == 2'd0) w_data[ICW1_INIT] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= C_IDLE;
      is_init     <= 1'b0;
      cmd_rd      <= 1'b0;
      cmd_a0_q    <= 1'b0;
      cmd_data_q  <= '0;
      icw_q       <= '0;
      idx         <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_err_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      case (st)
        C_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            cmd_a0_q    <= bus.cmd_a0;
            cmd_data_q  <= bus.cmd_data;
            icw_q       <= {bus.cfg_icw4, bus.cfg_icw3, bus.cfg_icw2, bus.cfg_icw1};
            idx         <= '0;
            is_init     <= (bus.cmd_op == OP_INIT);
            cmd_rd      <= (bus.cmd_op == OP_READ);
            if (bus.cmd_op == OP_INIT) begin
              init_done_q <= 1'b0;
              st          <= C_LAUNCH;
            end else if ((bus.cmd_op == OP_WRITE || bus.cmd_op == OP_READ) && init_done_q)
              st <= C_LAUNCH;
            else
              st <= C_ERR;
          end
        end
        C_LAUNCH: st <= C_BUSY;
        C_BUSY: begin
          if (bc_done) begin
            if (more) idx <= nxt.idx;
            else begin
              st          <= C_IDLE;
              cmd_ready_q <= 1'b1;
              init_done_q <= init_done_q | is_init;
              rsp_valid_q <= cmd_rd;
              if (cmd_rd) rsp_data_q <= bc_rd_data;
            end
          end
        end
        default: begin
          st          <= C_IDLE;
          cmd_err_q   <= 1'b1;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.init_done = init_done_q;

  pic_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_bus (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_read(cmd_rd),
    .a0     (w_a0),
    .data   (w_data),
    .d_in   (bus.d_in),
    .cs_n   (bus.cs_n),
    .wr_n   (bus.wr_n),
    .rd_n   (bus.rd_n),
    .pin_a0 (bus.a0),
    .d_out  (bus.d_out),
    .d_oe   (bus.d_oe),
    .done   (bc_done),
    .rd_data(bc_rd_data)
  );
endmodule
